// File: rtl/regfile_sequencer_if.sv
// Request channel from the instruction decoder into regfile_sequencer.
// The decoder holds the master side; the sequencer holds the slave side.
interface regfile_sequencer_if #(
  parameter int DW = 10,
  parameter int AW = 2
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_src0;
  logic [AW-1:0] req_src1;
  logic [AW-1:0] req_dst;
  logic [DW-1:0] req_imm;

  modport master (
    output req_valid, req_op, req_src0, req_src1, req_dst, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_src0, req_src1, req_dst, req_imm,
    output req_ready
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Runs one register-file operation at a time: read, ALU exec window, writeback.
// Define REGSEQ_DEBUG_EN to add the debug read/write port (DREAD/DCAP states).
module regfile_sequencer #(
  parameter int DW          = 10,
  parameter int AW          = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic          CLKb,
  input  logic          RSTb,
  regfile_sequencer_if.slave req,
  input  logic [DW-1:0] alu_result,
  output logic          operands_vld,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rf_D,
  output logic          rf_ENW,
  output logic [AW-1:0] rf_WRA,
  output logic          rf_ENR0,
  output logic          rf_ENR1,
  output logic [AW-1:0] rf_RDA0,
  output logic [AW-1:0] rf_RDA1
`ifdef REGSEQ_DEBUG_EN
  ,
  input  logic          dbg_valid,
  output logic          dbg_ready,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  input  logic [DW-1:0] rf_Q0
`endif
);

  localparam logic [1:0] OP_RR  = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

`ifdef REGSEQ_DEBUG_EN
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DREAD, DCAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
`endif

  state_t        state;
  logic [3:0]    cnt;
  logic [1:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [DW-1:0] imm_q;
  logic          wsel_alu;

`ifdef REGSEQ_DEBUG_EN
  assign req.req_ready = !busy && !dbg_valid;
  assign dbg_ready     = !busy;
`else
  assign req.req_ready = !busy;
`endif

  // ALU result is only meaningful during WRITE, so it is muxed in rather than registered.
  assign rf_D = !rf_ENW ? '0 : (wsel_alu ? alu_result : imm_q);

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= '0;
      dst_q        <= '0;
      imm_q        <= '0;
      wsel_alu     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      operands_vld <= 1'b0;
      rf_ENW       <= 1'b0;
      rf_WRA       <= '0;
      rf_ENR0      <= 1'b0;
      rf_ENR1      <= 1'b0;
      rf_RDA0      <= '0;
      rf_RDA1      <= '0;
`ifdef REGSEQ_DEBUG_EN
      dbg_rdata    <= '0;
`endif
    end else begin
      done         <= 1'b0;
      operands_vld <= 1'b0;
      rf_ENW       <= 1'b0;
      rf_WRA       <= '0;
      rf_ENR0      <= 1'b0;
      rf_ENR1      <= 1'b0;
      case (state)
        IDLE: begin
`ifdef REGSEQ_DEBUG_EN
          if (dbg_valid) begin
            busy     <= 1'b1;
            dst_q    <= dbg_addr;
            imm_q    <= dbg_wdata;
            wsel_alu <= 1'b0;
            if (dbg_we) begin
              state  <= WRITE;
              rf_ENW <= 1'b1;
              rf_WRA <= dbg_addr;
              done   <= 1'b1;
            end else begin
              state   <= DREAD;
              rf_ENR0 <= 1'b1;
              rf_RDA0 <= dbg_addr;
            end
          end else
`endif
          if (req.req_valid) begin
            busy     <= 1'b1;
            op_q     <= req.req_op;
            dst_q    <= req.req_dst;
            imm_q    <= req.req_imm;
            wsel_alu <= (req.req_op != OP_LDI);
            if (req.req_op == OP_LDI) begin
              state  <= WRITE;
              rf_ENW <= 1'b1;
              rf_WRA <= req.req_dst;
              done   <= 1'b1;
            end else begin
              state   <= READ;
              rf_ENR0 <= 1'b1;
              rf_ENR1 <= (req.req_op == OP_RR) || (req.req_op == OP_CMP);
              rf_RDA0 <= req.req_src0;
              rf_RDA1 <= req.req_src1;
            end
          end
        end
        READ: begin
          state        <= EXEC;
          cnt          <= CNT_LOAD;
          operands_vld <= 1'b1;
          if (CNT_LOAD == 4'd0 && op_q == OP_CMP) done <= 1'b1;
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            if (op_q == OP_CMP) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state  <= WRITE;
              rf_ENW <= 1'b1;
              rf_WRA <= dst_q;
              done   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1 && op_q == OP_CMP) done <= 1'b1;
          end
        end
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`ifdef REGSEQ_DEBUG_EN
        DREAD: begin
          state <= DCAP;
          done  <= 1'b1;
        end
        DCAP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          dbg_rdata <= rf_Q0;
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a falling-edge register-file model
// and an adder ALU; a second instance with EXEC_CYCLES=3 covers the longer CMP.
module tb_regfile_sequencer;
  localparam int DW = 10;
  localparam int AW = 2;
  localparam logic [1:0] RR = 2'b00, RI = 2'b01, LDI = 2'b10, CMP = 2'b11;

  logic CLKb = 1'b1;
  logic RSTb = 1'b0;
  always #5 CLKb = ~CLKb;

  regfile_sequencer_if #(.DW(DW), .AW(AW)) rq ();
  regfile_sequencer_if #(.DW(DW), .AW(AW)) rq3 ();

  logic [DW-1:0] alu_result, rf_D, rf_D3;
  logic          operands_vld, busy, done, rf_ENW, rf_ENR0, rf_ENR1;
  logic [AW-1:0] rf_WRA, rf_RDA0, rf_RDA1;
  logic          operands_vld3, busy3, done3, rf_ENW3, rf_ENR03, rf_ENR13;
  logic [AW-1:0] rf_WRA3, rf_RDA03, rf_RDA13;

  logic [DW-1:0] regs [4];
  logic [DW-1:0] q0, q1, alu_hold, alu_bias;
  int total = 0;
  int bad   = 0;

`ifdef REGSEQ_DEBUG_EN
  logic          dbg_valid, dbg_ready, dbg_we, dbg_ready3;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata, dbg_rdata3;
`endif

  regfile_sequencer #(.DW(DW), .AW(AW), .EXEC_CYCLES(1)) dut (
    .CLKb(CLKb), .RSTb(RSTb), .req(rq.slave), .alu_result(alu_result),
    .operands_vld(operands_vld), .busy(busy), .done(done), .rf_D(rf_D),
    .rf_ENW(rf_ENW), .rf_WRA(rf_WRA), .rf_ENR0(rf_ENR0), .rf_ENR1(rf_ENR1),
    .rf_RDA0(rf_RDA0), .rf_RDA1(rf_RDA1)
`ifdef REGSEQ_DEBUG_EN
    , .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .rf_Q0(q0)
`endif
  );

  regfile_sequencer #(.DW(DW), .AW(AW), .EXEC_CYCLES(3)) dut3 (
    .CLKb(CLKb), .RSTb(RSTb), .req(rq3.slave), .alu_result('0),
    .operands_vld(operands_vld3), .busy(busy3), .done(done3), .rf_D(rf_D3),
    .rf_ENW(rf_ENW3), .rf_WRA(rf_WRA3), .rf_ENR0(rf_ENR03), .rf_ENR1(rf_ENR13),
    .rf_RDA0(rf_RDA03), .rf_RDA1(rf_RDA13)
`ifdef REGSEQ_DEBUG_EN
    , .dbg_valid(1'b0), .dbg_ready(dbg_ready3), .dbg_we(1'b0),
    .dbg_addr('0), .dbg_wdata('0), .dbg_rdata(dbg_rdata3), .rf_Q0('0)
`endif
  );

  initial for (int i = 0; i < 4; i++) regs[i] = '0;

  // Register file: synchronous on the falling edge, Q zeroed when not read.
  always @(negedge CLKb) begin
    if (rf_ENW) regs[rf_WRA] <= rf_D;
    q0 <= rf_ENR0 ? regs[rf_RDA0] : '0;
    q1 <= rf_ENR1 ? regs[rf_RDA1] : '0;
    if (operands_vld) alu_hold <= q0 + q1 + alu_bias;
  end
  assign alu_result = alu_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                       input logic [AW-1:0] dst, input logic [DW-1:0] imm);
    rq.req_op = op; rq.req_src0 = s0; rq.req_src1 = s1; rq.req_dst = dst; rq.req_imm = imm;
    rq.req_valid = 1'b1;
    @(posedge CLKb);
    rq.req_valid = 1'b0;
  endtask

  initial begin
    rq.req_valid = 0; rq.req_op = '0; rq.req_src0 = '0; rq.req_src1 = '0;
    rq.req_dst = '0; rq.req_imm = '0;
    rq3.req_valid = 0; rq3.req_op = '0; rq3.req_src0 = '0; rq3.req_src1 = '0;
    rq3.req_dst = '0; rq3.req_imm = '0;
    alu_bias = '0;
`ifdef REGSEQ_DEBUG_EN
    dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
`endif
    repeat (2) @(posedge CLKb);
    chk("rst_ready", 32'(rq.req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_enw", 32'(rf_ENW), 0);
    chk("rst_enr0", 32'(rf_ENR0), 0);
    chk("rst_ovld", 32'(operands_vld), 0);
    chk("rst_rfd", 32'(rf_D), 0);
    chk("rst_ready3", 32'(rq3.req_ready), 1);
    RSTb = 1'b1;
    @(posedge CLKb);

    // LDI r2 = 155
    issue(LDI, 0, 0, 2, 10'h155);
    chk("ldi_enw", 32'(rf_ENW), 1);
    chk("ldi_wra", 32'(rf_WRA), 2);
    chk("ldi_rfd", 32'(rf_D), 32'h155);
    chk("ldi_done", 32'(done), 1);
    chk("ldi_ready", 32'(rq.req_ready), 0);
    @(posedge CLKb);
    chk("ldi_r2", 32'(regs[2]), 32'h155);
    chk("ldi_enw_off", 32'(rf_ENW), 0);
    chk("ldi_rfd_off", 32'(rf_D), 0);
    chk("ldi_idle", 32'(busy), 0);

    issue(LDI, 0, 0, 1, 10'd5); @(posedge CLKb);
    issue(LDI, 0, 0, 3, 10'd7); @(posedge CLKb);

    // RR r0 = r1 + r3
    issue(RR, 1, 3, 0, 0);
    chk("rr_enr0", 32'(rf_ENR0), 1);
    chk("rr_enr1", 32'(rf_ENR1), 1);
    chk("rr_rda0", 32'(rf_RDA0), 1);
    chk("rr_rda1", 32'(rf_RDA1), 3);
    chk("rr_read_done", 32'(done), 0);
    @(posedge CLKb);
    chk("rr_ovld", 32'(operands_vld), 1);
    chk("rr_q0", 32'(q0), 5);
    chk("rr_q1", 32'(q1), 7);
    @(posedge CLKb);
    chk("rr_enw", 32'(rf_ENW), 1);
    chk("rr_wra", 32'(rf_WRA), 0);
    chk("rr_rfd", 32'(rf_D), 12);
    chk("rr_done", 32'(done), 1);
    @(posedge CLKb);
    chk("rr_r0", 32'(regs[0]), 12);
    chk("rr_ovld_off", 32'(operands_vld), 0);

    // RI r3 = r3 + 3, destination equals source
    alu_bias = 10'd3;
    issue(RI, 3, 0, 3, 0);
    chk("ri_enr1", 32'(rf_ENR1), 0);
    chk("ri_rda0", 32'(rf_RDA0), 3);
    @(posedge CLKb);
    @(posedge CLKb);
    chk("ri_rfd", 32'(rf_D), 10);
    chk("ri_wra", 32'(rf_WRA), 3);
    @(posedge CLKb);
    chk("ri_r3", 32'(regs[3]), 10);
    alu_bias = '0;

    // CMP r2, r2
    issue(CMP, 2, 2, 1, 0);
    chk("cmp_enr1", 32'(rf_ENR1), 1);
    chk("cmp_rda1", 32'(rf_RDA1), 2);
    @(posedge CLKb);
    chk("cmp_done", 32'(done), 1);
    chk("cmp_ovld", 32'(operands_vld), 1);
    chk("cmp_enw", 32'(rf_ENW), 0);
    @(posedge CLKb);
    chk("cmp_idle", 32'(busy), 0);
    chk("cmp_done_off", 32'(done), 0);
    chk("cmp_r1_kept", 32'(regs[1]), 5);

    // CMP with EXEC_CYCLES=3
    rq3.req_op = CMP; rq3.req_src0 = 1; rq3.req_src1 = 2; rq3.req_dst = 0;
    rq3.req_valid = 1'b1;
    @(posedge CLKb);
    rq3.req_valid = 1'b0;
    chk("cmp3_read_done", 32'(done3), 0);
    @(posedge CLKb);
    chk("cmp3_ovld", 32'(operands_vld3), 1);
    chk("cmp3_e1_done", 32'(done3), 0);
    @(posedge CLKb);
    chk("cmp3_e2_done", 32'(done3), 0);
    chk("cmp3_e2_busy", 32'(busy3), 1);
    @(posedge CLKb);
    chk("cmp3_done", 32'(done3), 1);
    chk("cmp3_enw", 32'(rf_ENW3), 0);
    @(posedge CLKb);
    chk("cmp3_idle", 32'(busy3), 0);
    chk("cmp3_ready", 32'(rq3.req_ready), 1);

    // Back-to-back LDIs with req_valid held high
    rq.req_op = LDI; rq.req_dst = 1; rq.req_imm = 10'h02A; rq.req_valid = 1'b1;
    @(posedge CLKb);
    chk("b2b_wra1", 32'(rf_WRA), 1);
    chk("b2b_rfd1", 32'(rf_D), 32'h02A);
    chk("b2b_held", 32'(rq.req_ready), 0);
    rq.req_dst = 3; rq.req_imm = 10'h03B;
    @(posedge CLKb);
    chk("b2b_gap_ready", 32'(rq.req_ready), 1);
    chk("b2b_gap_enw", 32'(rf_ENW), 0);
    @(posedge CLKb);
    chk("b2b_wra2", 32'(rf_WRA), 3);
    chk("b2b_rfd2", 32'(rf_D), 32'h03B);
    rq.req_valid = 1'b0;
    @(posedge CLKb);
    chk("b2b_r1", 32'(regs[1]), 32'h02A);
    chk("b2b_r3", 32'(regs[3]), 32'h03B);

    // Reset asserted while an RR sits in EXEC
    issue(RR, 1, 3, 0, 0);
    @(posedge CLKb);
    chk("mid_exec_busy", 32'(busy), 1);
    RSTb = 1'b0;
    #1;
    chk("mid_rst_enw", 32'(rf_ENW), 0);
    chk("mid_rst_enr0", 32'(rf_ENR0), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(rq.req_ready), 1);
    chk("mid_rst_ovld", 32'(operands_vld), 0);
    @(posedge CLKb);
    RSTb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLKb);
      chk("mid_rst_no_done", 32'(done), 0);
      chk("mid_rst_no_write", 32'(rf_ENW), 0);
    end
    chk("mid_rst_r0_kept", 32'(regs[0]), 12);

`ifdef REGSEQ_DEBUG_EN
    // Debug read of r2 wins over a simultaneous LDI
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 2;
    rq.req_op = LDI; rq.req_dst = 0; rq.req_imm = 10'h099; rq.req_valid = 1'b1;
    #1;
    chk("dbg_req_blocked", 32'(rq.req_ready), 0);
    chk("dbg_ready", 32'(dbg_ready), 1);
    @(posedge CLKb);
    chk("dbg_enr0", 32'(rf_ENR0), 1);
    chk("dbg_rda0", 32'(rf_RDA0), 2);
    dbg_valid = 1'b0;
    @(posedge CLKb);
    chk("dbg_done", 32'(done), 1);
    chk("dbg_no_ovld", 32'(operands_vld), 0);
    @(posedge CLKb);
    chk("dbg_rdata", 32'(dbg_rdata), 32'h155);
    chk("dbg_then_ready", 32'(rq.req_ready), 1);
    @(posedge CLKb);
    chk("dbg_after_wra", 32'(rf_WRA), 0);
    chk("dbg_after_rfd", 32'(rf_D), 32'h099);
    chk("dbg_after_done", 32'(done), 1);
    rq.req_valid = 1'b0;
    @(posedge CLKb);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
